// File: rtl/ws2812b_frame_scheduler_pkg.sv
// Shared types and defaults for the WS2812B frame scheduler, the output module and top.
// Pixel words travel as packed GRB structs, G most significant so it leaves the wire first.
package ws2812b_frame_scheduler_pkg;

    localparam int unsigned GRB_W            = 24;
    localparam int unsigned LEDCOUNT_DEF     = 36;
    localparam int unsigned IDX_W_DEF        = 6;
    localparam int unsigned FRAME_CYCLES_DEF = 90000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_FILL,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

endpackage

// File: rtl/ws2812b_frame_scheduler_if.sv
// Pixel RAM read port plus the bitstream handshake toward ws2812b_out_module.
// The master side is the scheduler; the slave side is the RAM and the output module.
interface ws2812b_frame_scheduler_if
    import ws2812b_frame_scheduler_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) ();

    logic             rd_en;
    logic [IDX_W:0]   rd_addr;
    grb_t             rd_data;
    logic             bitstream_available;
    grb_t             bitstream;
    logic             bitstream_read;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output bitstream_available,
        output bitstream,
        input  bitstream_read
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  bitstream_available,
        input  bitstream,
        output bitstream_read
    );

endinterface

// File: rtl/ws2812b_frame_scheduler_frame_tick_gen.sv
// Free-running frame-rate down-counter; the tick is high while the count sits at zero.
// Counting restarts from zero on reset, so the first tick lands right after reset.
module ws2812b_frame_scheduler_frame_tick_gen
    import ws2812b_frame_scheduler_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tick_c_o = (cnt_q == '0);

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// Per-frame sequencer: fetches LEDCOUNT GRB words from the displayed RAM bank and hands
// them to the output module through a one-word prefetch plus one output register.
module ws2812b_frame_scheduler
    import ws2812b_frame_scheduler_pkg::*;
#(
    parameter int unsigned LEDCOUNT     = LEDCOUNT_DEF,
    parameter int unsigned IDX_W        = IDX_W_DEF,
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic swap_req,
    output logic swap_ack,
    output logic display_bank,
    output logic busy,
    output logic frame_done,
    output logic overrun,
    input  logic clear_overrun,
    ws2812b_frame_scheduler_if.master px
);

    // idx counts up to LEDCOUNT itself, which may equal 2**IDX_W
    localparam int unsigned IDXC_W = IDX_W + 1;
    localparam logic [IDXC_W-1:0] LAST_IDX = IDXC_W'(LEDCOUNT);

    state_e              state_q;
    logic [IDXC_W-1:0]   idx_q;
    logic                bank_q;
    logic                swap_ack_q;
    logic                busy_q;
    logic                done_q;
    logic                overrun_q;
    logic                rd_en_q;
    logic [IDX_W:0]      rd_addr_q;
    grb_t                pf_q;
    logic                pf_valid_q;
    grb_t                out_q;
    logic                avail_q;

    logic tick_c;
    logic start_c;
    logic bank_next_c;
    logic consume_c;
    logic move_c;
    logic pf_after_c;

    ws2812b_frame_scheduler_frame_tick_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .tick_c_o (tick_c)
    );

    assign start_c     = (state_q == ST_IDLE) && tick_c && enable;
    assign bank_next_c = bank_q ^ (start_c & swap_req);
    assign consume_c   = px.bitstream_read & avail_q;
    // Prefetch moves out whenever the output register is empty or being emptied this edge
    assign move_c      = pf_valid_q & (~avail_q | consume_c);
    assign pf_after_c  = pf_valid_q & ~move_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bank_q     <= 1'b0;
            swap_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            out_q      <= '0;
            avail_q    <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;

            if (tick_c && busy_q) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            if (move_c) begin
                out_q      <= pf_q;
                avail_q    <= 1'b1;
                pf_valid_q <= 1'b0;
            end else if (consume_c) begin
                avail_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        bank_q     <= bank_next_c;
                        swap_ack_q <= swap_req;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= {bank_next_c, IDX_W'(0)};
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    pf_q       <= px.rd_data;
                    pf_valid_q <= 1'b1;
                    idx_q      <= idx_q + IDXC_W'(1);
                    state_q    <= ST_FILL;
                end
                ST_FILL: begin
                    if (idx_q < LAST_IDX) begin
                        if (!pf_after_c) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= {bank_q, idx_q[IDX_W-1:0]};
                            state_q   <= ST_FETCH;
                        end
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Finish on the same edge that retires the last word
                    if (!pf_valid_q && (!avail_q || consume_c)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign swap_ack               = swap_ack_q;
    assign display_bank           = bank_q;
    assign busy                   = busy_q;
    assign frame_done             = done_q;
    assign overrun                = overrun_q;
    assign px.rd_en               = rd_en_q;
    assign px.rd_addr             = rd_addr_q;
    assign px.bitstream_available = avail_q;
    assign px.bitstream           = out_q;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Scoreboard bench for ws2812b_frame_scheduler: expected words and RAM addresses are queued
// by the stimulus, and a negedge monitor acting as the output module pops and compares.
module tb_ws2812b_frame_scheduler;
    import ws2812b_frame_scheduler_pkg::*;

    localparam int unsigned LEDCOUNT     = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned FRAME_CYCLES = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic swap_req = 1'b0;
    logic clear_overrun = 1'b0;
    logic swap_ack, display_bank, busy, frame_done, overrun;

    ws2812b_frame_scheduler_if #(.IDX_W(IDX_W)) px ();

    ws2812b_frame_scheduler #(
        .LEDCOUNT     (LEDCOUNT),
        .IDX_W        (IDX_W),
        .FRAME_CYCLES (FRAME_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .display_bank  (display_bank),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .px            (px)
    );

    always #5 clk = ~clk;

    logic [23:0] words0 [4] = '{24'h0A0A01, 24'h0B0B02, 24'h0C0C03, 24'h0D0D04};
    logic [23:0] words1 [4] = '{24'h0E0E05, 24'h0F0F06, 24'h101007, 24'h111108};
    logic [23:0] mem [8];

    always @(posedge clk) begin
        if (px.rd_en) px.rd_data <= mem[px.rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int n_rd = 0, n_done = 0, n_swap = 0, n_busy_rise = 0, n_consume = 0;
    int read_period = 0;
    int wait_cnt = 0;
    logic busy_prev = 1'b0;
    logic [23:0]    exp_words [$];
    logic [IDX_W:0] exp_addrs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return n_busy_rise;
            1:       return n_done;
            2:       return n_consume;
            default: return int'(overrun);
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int limit, input string name);
        int k;
        k = 0;
        while (get_cnt(which) < target && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (get_cnt(which) < target) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, count %0d required %0d", name, k, get_cnt(which), target);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic push_frame(input logic bank);
        for (int i = 0; i < 4; i++) begin
            exp_words.push_back(bank ? words1[i] : words0[i]);
            exp_addrs.push_back({bank, 2'(i)});
        end
    endtask

    // Monitor + output-module model: a word is consumed at the posedge after read is raised
    always @(negedge clk) begin
        logic [23:0] w;
        if (reset) begin
            px.bitstream_read = 1'b0;
        end else begin
            if (px.rd_en) begin
                n_rd++;
                if (exp_addrs.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_addr: unexpected read of %0h", px.rd_addr);
                end else begin
                    check("rd_addr", 32'(px.rd_addr), 32'(exp_addrs.pop_front()));
                end
            end
            if (frame_done) n_done++;
            if (swap_ack) n_swap++;
            if (busy && !busy_prev) n_busy_rise++;
            px.bitstream_read = 1'b0;
            if (px.bitstream_available && read_period > 0) begin
                if (wait_cnt >= read_period - 1) begin
                    px.bitstream_read = 1'b1;
                    wait_cnt = 0;
                    n_consume++;
                    w = px.bitstream;
                    if (exp_words.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bitstream: unexpected word %0h", w);
                    end else begin
                        check("bitstream", 32'(w), 32'(exp_words.pop_front()));
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_base, done_base, rise_base, swap_base, cons_base;
        logic [23:0] w;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = words0[i];
            mem[i + 4] = words1[i];
        end

        // Reset state
        cycles(3);
        check("rst_swap_ack", 32'(swap_ack), 32'd0);
        check("rst_display_bank", 32'(display_bank), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_en", 32'(px.rd_en), 32'd0);
        check("rst_rd_addr", 32'(px.rd_addr), 32'd0);
        check("rst_available", 32'(px.bitstream_available), 32'd0);
        w = px.bitstream;
        check("rst_bitstream", 32'(w), 32'd0);
        reset = 1'b0;
        cycles(5);
        check("idle_without_enable", 32'(busy), 32'd0);

        // 1: slow consumer, bank 0
        read_period = 30;
        push_frame(1'b0);
        rd_base = n_rd;
        enable = 1'b1;
        wait_for(0, 1, 250, "t1_start");
        wait_for(1, 1, 400, "t1_done");
        enable = 1'b0;
        check("t1_frame_done_pulse", 32'(frame_done), 32'd1);
        check("t1_busy_dropped", 32'(busy), 32'd0);
        check("t1_available_dropped", 32'(px.bitstream_available), 32'd0);
        check("t1_rd_count", 32'(n_rd - rd_base), 32'd4);
        cycles(1);
        check("t1_done_is_pulse", 32'(frame_done), 32'd0);

        // 2: consumer reads every cycle
        read_period = 1;
        push_frame(1'b0);
        rd_base = n_rd; cons_base = n_consume;
        enable = 1'b1;
        wait_for(0, 2, 250, "t2_start");
        wait_for(1, 2, 400, "t2_done");
        enable = 1'b0;
        check("t2_rd_count", 32'(n_rd - rd_base), 32'd4);
        check("t2_consume_count", 32'(n_consume - cons_base), 32'd4);

        // 3: swap requested mid-frame is applied at the next frame start
        read_period = 5;
        push_frame(1'b0);
        swap_base = n_swap;
        enable = 1'b1;
        wait_for(0, 3, 250, "t3_start_a");
        cycles(3);
        swap_req = 1'b1;
        wait_for(1, 3, 400, "t3_done_a");
        check("t3_bank_held", 32'(display_bank), 32'd0);
        check("t3_no_early_ack", 32'(n_swap - swap_base), 32'd0);
        push_frame(1'b1);
        wait_for(0, 4, 250, "t3_start_b");
        swap_req = 1'b0;
        check("t3_bank_swapped", 32'(display_bank), 32'd1);
        check("t3_ack_count", 32'(n_swap - swap_base), 32'd1);
        wait_for(1, 4, 400, "t3_done_b");
        enable = 1'b0;

        // 4: stalled consumer -> overrun, no restart, clear, then completion
        read_period = 0;
        push_frame(1'b1);
        rd_base = n_rd; rise_base = n_busy_rise;
        enable = 1'b1;
        wait_for(0, rise_base + 1, 250, "t4_start");
        enable = 1'b0;
        wait_for(3, 1, 300, "t4_overrun");
        check("t4_still_busy", 32'(busy), 32'd1);
        check("t4_rd_count_stalled", 32'(n_rd - rd_base), 32'd2);
        w = px.bitstream;
        check("t4_held_word", 32'(w), 32'h0E0E05);
        check("t4_no_restart", 32'(n_busy_rise - rise_base), 32'd1);
        clear_overrun = 1'b1;
        cycles(1);
        clear_overrun = 1'b0;
        check("t4_overrun_cleared", 32'(overrun), 32'd0);
        read_period = 5;
        done_base = n_done;
        wait_for(1, done_base + 1, 400, "t4_done");
        check("t4_rd_count", 32'(n_rd - rd_base), 32'd4);

        // 5: reset while the third word is on the bitstream
        read_period = 30;
        exp_words.push_back(words1[0]);
        exp_words.push_back(words1[1]);
        for (int i = 0; i < 4; i++) exp_addrs.push_back({1'b1, 2'(i)});
        rd_base = n_rd; done_base = n_done; cons_base = n_consume; rise_base = n_busy_rise;
        enable = 1'b1;
        wait_for(0, rise_base + 1, 250, "t5_start");
        wait_for(2, cons_base + 2, 200, "t5_two_words");
        cycles(5);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t5_rst_available", 32'(px.bitstream_available), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_display_bank", 32'(display_bank), 32'd0);
        w = px.bitstream;
        check("t5_rst_bitstream", 32'(w), 32'd0);
        check("t5_rd_count", 32'(n_rd - rd_base), 32'd4);
        cycles(3);
        check("t5_no_frame_done", 32'(n_done - done_base), 32'd0);
        push_frame(1'b0);
        rise_base = n_busy_rise; done_base = n_done;
        reset = 1'b0;
        wait_for(0, rise_base + 1, 250, "t5_restart");
        check("t5_restart_bank", 32'(display_bank), 32'd0);
        wait_for(1, done_base + 1, 400, "t5_done");
        enable = 1'b0;

        // 6: enable dropped mid-frame -> frame completes, later ticks ignored
        read_period = 10;
        push_frame(1'b0);
        rise_base = n_busy_rise; done_base = n_done;
        enable = 1'b1;
        wait_for(0, rise_base + 1, 250, "t6_start");
        cycles(5);
        enable = 1'b0;
        wait_for(1, done_base + 1, 400, "t6_done");
        rd_base = n_rd; rise_base = n_busy_rise;
        cycles(450);
        check("t6_one_done", 32'(n_done - done_base), 32'd1);
        check("t6_no_new_frame", 32'(n_busy_rise - rise_base), 32'd0);
        check("t6_no_reads", 32'(n_rd - rd_base), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        check("words_left", 32'(exp_words.size()), 32'd0);
        check("addrs_left", 32'(exp_addrs.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
